// File: rtl/md_unit_pkg.sv
//------------------------------------------------------------------------------
// Module : md_defs (package)
// Brief  : Shared MDOp codes, FSM states and constants for the mult/div unit.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package md_defs;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/md_unit_calc.sv
//------------------------------------------------------------------------------
// Module : md_calc
// Brief  : Combinational {hi, lo} generator for mult/multu/div/divu.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_calc
    import md_defs::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [63:0] result
);

    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_qs_mag;
    logic [31:0]        w_rs_mag;
    logic [31:0]        w_qs;
    logic [31:0]        w_rs;
    logic [31:0]        w_qu;
    logic [31:0]        w_ru;
    logic               w_b_zero;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide done on magnitudes so 0x80000000 / -1 cannot overflow.
    assign w_a_mag  = a[31] ? (~a + 32'd1) : a;
    assign w_b_mag  = b[31] ? (~b + 32'd1) : b;
    assign w_b_zero = (b == 32'd0);
    assign w_qs_mag = w_b_zero ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_rs_mag = w_b_zero ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_qs     = (a[31] ^ b[31]) ? (~w_qs_mag + 32'd1) : w_qs_mag;
    assign w_rs     = a[31] ? (~w_rs_mag + 32'd1) : w_rs_mag;
    assign w_qu     = w_b_zero ? 32'd0 : (a / b);
    assign w_ru     = w_b_zero ? 32'd0 : (a % b);

    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = w_prod_s;
            MD_MULTU: result = w_prod_u;
            MD_DIV:   result = w_b_zero ? {a, DIVZERO_LO} : {w_rs, w_qs};
            MD_DIVU:  result = w_b_zero ? {a, DIVZERO_LO} : {w_ru, w_qu};
            default:  result = 64'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
//------------------------------------------------------------------------------
// Module : md_unit
// Brief  : Multi-cycle MIPS mult/div unit with HI/LO; optional flush via
//          macro MD_FLUSH_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        start,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = ($clog2(c_max_cycles) < 1) ? 1 : $clog2(c_max_cycles);
    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES - 1);

    md_state_t          r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [63:0]        r_pending;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_busy;
    logic [63:0]        w_result;
    logic               w_flush;
    logic               w_accept;

`ifdef MD_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && start && !w_flush;

    md_calc u_calc (
        .a      (A),
        .b      (B),
        .op     (MDOp),
        .result (w_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pending <= 64'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (MDOp)
                            MD_MULT, MD_MULTU: begin
                                r_pending <= w_result;
                                r_cnt     <= c_mult_load;
                                r_state   <= ST_RUN;
                                r_busy    <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_pending <= w_result;
                                r_cnt     <= c_div_load;
                                r_state   <= ST_RUN;
                                r_busy    <= 1'b1;
                            end
                            MD_MTHI: r_hi <= A;
                            MD_MTLO: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // Flush outranks a commit landing on the same edge.
                    if (w_flush) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_pending <= 64'd0;
                    end else if (r_cnt == '0) begin
                        r_hi    <= r_pending[63:32];
                        r_lo    <= r_pending[31:0];
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

`default_nettype wire
